piece_motion_ctrl: RTL and testbench

- Upstream stage of color_mapper in the falling-block game.
- Owns the four block positions of the active piece and drives them onto BallX/BallY … BallX4/BallY4 and Ball_size.
- Reacts to USB keycodes and per-frame gravity, clamps motion to the playfield between the side borders and above the bottom border, and respawns the next shape when the piece lands.

---
 rtl/piece_motion_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_piece_motion_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/piece_motion_ctrl.sv
// piece_motion_ctrl: owns the four blocks of the active falling piece.
// Handles keyboard moves and per-frame gravity. Landing is detected at the
// bottom row, and the next shape is respawned at the anchor.
// Optional build macro: PIECE_ROTATE_EN enables clockwise rotation on keycode 0x1A.
module piece_motion_ctrl #(
    parameter int GRAV_FRAMES = 30,
    parameter int FIELD_X0    = 200,
    parameter int CELL        = 20,
    parameter int COLS        = 10,
    parameter int ROWS        = 21,
    parameter int SPAWN_COL   = 3
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [7:0] keycode,
    output logic [9:0] BallX,
    output logic [9:0] BallY,
    output logic [9:0] BallX2,
    output logic [9:0] BallY2,
    output logic [9:0] BallX3,
    output logic [9:0] BallY3,
    output logic [9:0] BallX4,
    output logic [9:0] BallY4,
    output logic [9:0] Ball_size,
    output logic       piece_landed
);
    localparam logic [7:0] KEY_LEFT  = 8'h04;
    localparam logic [7:0] KEY_RIGHT = 8'h07;
    localparam logic [7:0] KEY_DROP  = 8'h16;
`ifdef PIECE_ROTATE_EN
    localparam logic [7:0] KEY_ROT   = 8'h1A;
`endif
    localparam int CNT_W = $clog2(GRAV_FRAMES);

    typedef enum logic [1:0] {FALL, LAND, SPAWN} state_t;

    // Block column of each block of shape s, placed at the spawn anchor.
    function automatic logic [3:0][3:0] shape_cols(input logic [1:0] s);
        logic [3:0][3:0] off;
        case (s)
            2'd0:    off = {4'd3, 4'd2, 4'd1, 4'd0};   // I
            2'd1:    off = {4'd1, 4'd0, 4'd1, 4'd0};   // O
            2'd2:    off = {4'd1, 4'd2, 4'd1, 4'd0};   // T
            default: off = {4'd1, 4'd0, 4'd0, 4'd0};   // L
        endcase
        for (int i = 0; i < 4; i++) off[i] = off[i] + 4'(SPAWN_COL);
        return off;
    endfunction

    // Block row of each block of shape s; the anchor row is 0.
    function automatic logic [3:0][4:0] shape_rows(input logic [1:0] s);
        case (s)
            2'd0:    return {5'd0, 5'd0, 5'd0, 5'd0};
            2'd1:    return {5'd1, 5'd1, 5'd0, 5'd0};
            2'd2:    return {5'd1, 5'd0, 5'd0, 5'd0};
            default: return {5'd2, 5'd2, 5'd1, 5'd0};
        endcase
    endfunction

    function automatic logic [9:0] pix_x(input logic [3:0] c);
        return 10'(FIELD_X0) + 10'(c) * 10'(CELL);
    endfunction

    function automatic logic [9:0] pix_y(input logic [4:0] r);
        return 10'(r) * 10'(CELL);
    endfunction

    state_t           state, state_nxt;
    logic [1:0]       shape, shape_nxt;
    logic [3:0][3:0]  col, col_nxt;
    logic [3:0][4:0]  row, row_nxt;
    logic [CNT_W-1:0] grav_cnt, grav_cnt_nxt;
    logic [7:0]       prev_key;
    logic [2:0]       frame_sync;
    logic             tick;
    logic             new_press, can_left, can_right, grav_due, at_bottom;
    logic [3:0][9:0]  pos_x, pos_y;
`ifdef PIECE_ROTATE_EN
    logic signed [6:0] rot_c [4];
    logic signed [6:0] rot_r [4];
    logic              rot_ok;
`endif

    // Bits 0-1 synchronise frame_clk; bit 2 keeps the previous value for rising-edge detect.
    assign tick = frame_sync[1] & ~frame_sync[2];

    // Next-state and next-position logic, evaluated once per frame tick while falling.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
        state_nxt    = state;
        shape_nxt    = shape;
        col_nxt      = col;
        row_nxt      = row;
        grav_cnt_nxt = grav_cnt;
        new_press    = 1'b0;
        can_left     = 1'b1;
        can_right    = 1'b1;
        grav_due     = 1'b0;
        at_bottom    = 1'b0;
`ifdef PIECE_ROTATE_EN
        rot_ok       = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rot_c[i] = '0;
            rot_r[i] = '0;
        end
`endif
        case (state)
            FALL: if (tick) begin
                new_press = (keycode != prev_key);
`ifdef PIECE_ROTATE_EN
                // Clockwise about block 2; rejected if any block leaves the field.
                if (new_press && keycode == KEY_ROT) begin
                    for (int i = 0; i < 4; i++) begin
                        rot_c[i] = signed'(7'(col[1])) - (signed'(7'(row[i])) - signed'(7'(row[1])));
                        rot_r[i] = signed'(7'(row[1])) + (signed'(7'(col[i])) - signed'(7'(col[1])));
                        if (rot_c[i] < 0 || rot_c[i] > 7'(COLS - 1) ||
                            rot_r[i] < 0 || rot_r[i] > 7'(ROWS - 1))
                            rot_ok = 1'b0;
                    end
                    if (rot_ok) begin
                        for (int i = 0; i < 4; i++) begin
                            col_nxt[i] = rot_c[i][3:0];
                            row_nxt[i] = rot_r[i][4:0];
                        end
                    end
                end
`endif
                for (int i = 0; i < 4; i++) begin
                    if (col_nxt[i] == 4'd0)          can_left  = 1'b0;
                    if (col_nxt[i] == 4'(COLS - 1))  can_right = 1'b0;
                end
                if (new_press && keycode == KEY_LEFT && can_left)
                    for (int i = 0; i < 4; i++) col_nxt[i] = col_nxt[i] - 4'd1;
                else if (new_press && keycode == KEY_RIGHT && can_right)
                    for (int i = 0; i < 4; i++) col_nxt[i] = col_nxt[i] + 4'd1;

                grav_due     = (grav_cnt == CNT_W'(GRAV_FRAMES - 1)) || (keycode == KEY_DROP);
                grav_cnt_nxt = grav_due ? '0 : grav_cnt + 1'b1;
                for (int i = 0; i < 4; i++)
                    if (row_nxt[i] == 5'(ROWS - 1)) at_bottom = 1'b1;
                if (grav_due) begin
                    if (at_bottom) state_nxt = LAND;
                    else for (int i = 0; i < 4; i++) row_nxt[i] = row_nxt[i] + 5'd1;
                end
            end
            LAND: state_nxt = SPAWN;
            SPAWN: begin
                shape_nxt    = shape + 2'd1;
                col_nxt      = shape_cols(shape + 2'd1);
                row_nxt      = shape_rows(shape + 2'd1);
                grav_cnt_nxt = '0;
                state_nxt    = FALL;
            end
            default: state_nxt = FALL;
        endcase
    end

    // State, piece position and registered pixel outputs.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state      <= FALL;
            shape      <= 2'd0;
            col        <= shape_cols(2'd0);
            row        <= shape_rows(2'd0);
            grav_cnt   <= '0;
            prev_key   <= 8'h00;
            frame_sync <= 3'b000;
            for (int i = 0; i < 4; i++) begin
                pos_x[i] <= pix_x(shape_cols(2'd0)[i]);
                pos_y[i] <= pix_y(shape_rows(2'd0)[i]);
            end
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state      <= state_nxt;
            shape      <= shape_nxt;
            col        <= col_nxt;
            row        <= row_nxt;
            grav_cnt   <= grav_cnt_nxt;
            frame_sync <= {frame_sync[1:0], frame_clk};
            if (tick) prev_key <= keycode;
            for (int i = 0; i < 4; i++) begin
                pos_x[i] <= pix_x(col_nxt[i]);
                pos_y[i] <= pix_y(row_nxt[i]);
            end
        end
    end

    assign BallX        = pos_x[0];
    assign BallY        = pos_y[0];
    assign BallX2       = pos_x[1];
    assign BallY2       = pos_y[1];
    assign BallX3       = pos_x[2];
    assign BallY3       = pos_y[2];
    assign BallX4       = pos_x[3];
    assign BallY4       = pos_y[3];
    assign Ball_size    = 10'(CELL);
    assign piece_landed = (state == LAND);
endmodule

// File: tb/tb_piece_motion_ctrl.sv
// Testbench for piece_motion_ctrl: a reference model of the game rules feeds a
// scoreboard queue, and a monitor compares the DUT after every frame tick.
module tb_piece_motion_ctrl;
    localparam int CELL      = 20;
    localparam int FIELD_X0  = 200;
    localparam int COLS      = 10;
    localparam int ROWS      = 21;
    localparam int SPAWN_COL = 3;
    localparam int GRAV      = 30;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       frame_clk;
    logic [7:0] keycode;
    logic [9:0] BallX, BallY, BallX2, BallY2, BallX3, BallY3, BallX4, BallY4, Ball_size;
    logic       piece_landed;

    piece_motion_ctrl dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .keycode(keycode),
        .BallX(BallX), .BallY(BallY), .BallX2(BallX2), .BallY2(BallY2),
        .BallX3(BallX3), .BallY3(BallY3), .BallX4(BallX4), .BallY4(BallY4),
        .Ball_size(Ball_size), .piece_landed(piece_landed)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [79:0] pos;
        int          landed;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: block positions as plain integers.
    int off_c [4][4] = '{'{0, 1, 2, 3}, '{0, 1, 0, 1}, '{0, 1, 2, 1}, '{0, 0, 0, 1}};
    int off_r [4][4] = '{'{0, 0, 0, 0}, '{0, 0, 1, 1}, '{0, 0, 0, 1}, '{0, 1, 2, 2}};
    int mc [4];
    int mr [4];
    int m_shape, m_cnt, m_prev;

    function automatic void model_spawn(int s);
        for (int i = 0; i < 4; i++) begin
            mc[i] = SPAWN_COL + off_c[s][i];
            mr[i] = off_r[s][i];
        end
    endfunction

    function automatic void model_reset();
        m_shape = 0;
        m_cnt   = 0;
        m_prev  = 0;
        model_spawn(0);
    endfunction

    // One frame tick; returns 1 if the piece lands (and a new one spawns).
    function automatic int model_tick(int key);
        bit press = (key != m_prev);
        bit ok;
        bit due;
        int nc [4];
        int nr [4];
        m_prev = key;
`ifdef PIECE_ROTATE_EN
        if (press && key == 'h1A) begin
            ok = 1;
            for (int i = 0; i < 4; i++) begin
                nc[i] = mc[1] - (mr[i] - mr[1]);
                nr[i] = mr[1] + (mc[i] - mc[1]);
                if (nc[i] < 0 || nc[i] >= COLS || nr[i] < 0 || nr[i] >= ROWS) ok = 0;
            end
            if (ok) for (int i = 0; i < 4; i++) begin mc[i] = nc[i]; mr[i] = nr[i]; end
        end
`endif
        if (press && (key == 'h04 || key == 'h07)) begin
            ok = 1;
            for (int i = 0; i < 4; i++) begin
                nc[i] = mc[i] + ((key == 'h04) ? -1 : 1);
                if (nc[i] < 0 || nc[i] >= COLS) ok = 0;
            end
            if (ok) for (int i = 0; i < 4; i++) mc[i] = nc[i];
        end
        due   = (m_cnt == GRAV - 1) || (key == 'h16);
        m_cnt = due ? 0 : m_cnt + 1;
        if (due) begin
            ok = 1;
            for (int i = 0; i < 4; i++) if (mr[i] == ROWS - 1) ok = 0;
            if (!ok) begin
                m_shape = (m_shape + 1) % 4;
                model_spawn(m_shape);
                m_cnt = 0;
                return 1;
            end
            for (int i = 0; i < 4; i++) mr[i] = mr[i] + 1;
        end
        return 0;
    endfunction

    function automatic logic [79:0] model_pos();
        logic [79:0] p;
        for (int i = 0; i < 4; i++) begin
            p[i*10 +: 10]      = 10'(FIELD_X0 + CELL * mc[i]);
            p[40 + i*10 +: 10] = 10'(CELL * mr[i]);
        end
        return p;
    endfunction

    function automatic logic [79:0] dut_pos();
        return {BallY4, BallY3, BallY2, BallY, BallX4, BallX3, BallX2, BallX};
    endfunction

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Issue one frame_clk pulse carrying key; the model's prediction goes to the scoreboard.
    task automatic frame(input logic [7:0] key);
        exp_t e;
        keycode  = key;
        e.landed = model_tick(int'(key));
        e.pos    = model_pos();
        sb.push_back(e);
        frame_clk = 1'b1;
        repeat (3) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (13) @(negedge Clk);
    endtask

    // Assert reset (asynchronously, between clock edges) and check the spawn state at once.
    task automatic do_reset();
        @(negedge Clk);
        #2;
        Reset = 1'b0;
        model_reset();
        sb.delete();
        #1;
        check("reset_pos", dut_pos(), model_pos());
        check("reset_landed", piece_landed, 0);
        check("reset_size", Ball_size, CELL);
        @(negedge Clk);
        Reset = 1'b1;
    endtask

    task automatic random_frames(input int n);
        logic [7:0] keys [8];
        keys = '{8'h00, 8'h00, 8'h04, 8'h07, 8'h16, 8'h1A, 8'h16, 8'h2C};
        for (int i = 0; i < n; i++) frame(keys[$urandom_range(7)]);
    endtask

    // Monitor: after each frame pulse, count landed cycles and compare the settled outputs.
    initial begin : monitor
        exp_t e;
        int   lc;
        forever begin
            @(posedge frame_clk);
            lc = 0;
            repeat (11) begin
                @(negedge Clk);
                if (piece_landed) lc++;
            end
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL scoreboard: DUT frame with no expected entry at %0t", $time);
            end else begin
                e = sb.pop_front();
                check("pos", dut_pos(), e.pos);
                check("landed", 80'(lc), 80'(e.landed));
                check("size", Ball_size, CELL);
            end
        end
    end

    initial begin : stimulus
        Reset     = 1'b0;
        frame_clk = 1'b0;
        keycode   = 8'h00;
        do_reset();

        // Gravity alone: 29 ticks at row 0, the 30th drops one row.
        repeat (30) frame(8'h00);
        // Held right acts once, then press/release cycles up to the right wall.
        repeat (10) frame(8'h07);
        repeat (4) begin frame(8'h00); frame(8'h07); end

        // Right press on a gravity tick, then at the wall on a gravity tick.
        do_reset();
        repeat (29) frame(8'h00);
        frame(8'h07);
        repeat (2) begin frame(8'h00); frame(8'h07); end
        repeat (25) frame(8'h00);
        frame(8'h07);

        // Soft drop to the floor, landing and respawn as O.
        do_reset();
        repeat (23) frame(8'h16);

        // Rotation at row 0 (rejected), then after two drops.
        do_reset();
        frame(8'h1A);
        frame(8'h16);
        frame(8'h16);
        frame(8'h1A);
        frame(8'h00);

        // Randomised play, reset while falling, more play.
        random_frames(200);
        do_reset();
        random_frames(30);

        repeat (20) @(negedge Clk);
        if (sb.size() != 0) begin
            n_checks++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
